// File: rtl/add_pred_res.sv
// Reconstruction adder: pops a paired pred/res from one flux and registers sat16(pred+res) with its tag. ADD_PRED_RES_RR_ARB_EN selects round-robin over fixed priority.
// Latency: 1 clk from pop to write. Throughput: 1 pel/clk with same-cycle drain and refill.
// Backpressure: a held result waits only on full[tag_q]. A flux pops only when both its inputs are present and its output is not full.
module add_pred_res #(
  parameter int FLUX            = 2,
  parameter int DATA_WIDTH_PRED = 8,
  parameter int DATA_WIDTH_RES  = 16,
  localparam int TAG_WIDTH      = $clog2(FLUX),
  localparam int PW             = TAG_WIDTH + DATA_WIDTH_PRED,
  localparam int RW             = TAG_WIDTH + DATA_WIDTH_RES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLUX-1:0]      read_port_in_pred_empty,
  input  logic [FLUX*PW-1:0]   read_port_in_pred_dout,
  output logic [FLUX-1:0]      read_port_in_pred_read,
  input  logic [FLUX-1:0]      read_port_in_res_empty,
  input  logic [FLUX*RW-1:0]   read_port_in_res_dout,
  output logic [FLUX-1:0]      read_port_in_res_read,
  input  logic [FLUX-1:0]      write_port_out_pel_full,
  output logic                 write_port_out_pel_write,
  output logic [RW-1:0]        write_port_out_pel_din
);
  localparam int TW = (TAG_WIDTH > 0) ? TAG_WIDTH : 1;
  localparam int SW = DATA_WIDTH_RES + 1;

  logic                       v_q, v_d;
  logic [TW-1:0]              tag_q, tag_d;
  logic [TW-1:0]              ptr_q, ptr_d;
  logic [DATA_WIDTH_RES-1:0]  sum_q, sum_d;

  logic [FLUX-1:0]            elig;
  logic [TW-1:0]              sel;
  logic                       write;
  logic                       fire;
  logic [DATA_WIDTH_PRED-1:0] pred_sel;
  logic [DATA_WIDTH_RES-1:0]  res_sel;
  logic signed [SW-1:0]       sum_wide;
  logic [DATA_WIDTH_RES-1:0]  sum_sat;

  assign elig  = ~read_port_in_pred_empty & ~read_port_in_res_empty & ~write_port_out_pel_full;
  assign write = v_q & ~write_port_out_pel_full[tag_q];
  assign fire  = (|elig) & (~v_q | write);

`ifdef ADD_PRED_RES_RR_ARB_EN
  always_comb begin
    logic found;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < FLUX; k++) begin
      if (!found && elig[(int'(ptr_q) + k) % FLUX]) begin
        found = 1'b1;
        sel   = TW'((int'(ptr_q) + k) % FLUX);
      end
    end
  end
`else
  // Descending scan so the lowest eligible index is the last one written.
  always_comb begin
    sel = '0;
    for (int k = FLUX - 1; k >= 0; k--) begin
      if (elig[k]) sel = TW'(k);
    end
  end

  logic ptr_unused;
  assign ptr_unused = ^ptr_q;
`endif

  // Input tag fields are ignored: the data lives in the low bits of each dout word.
  always_comb begin
    pred_sel = read_port_in_pred_dout[int'(sel)*PW +: DATA_WIDTH_PRED];
    res_sel  = read_port_in_res_dout[int'(sel)*RW +: DATA_WIDTH_RES];
    sum_wide = $signed(SW'({1'b0, pred_sel})) + $signed({res_sel[DATA_WIDTH_RES-1], res_sel});
    if (sum_wide[SW-1] != sum_wide[SW-2])
      sum_sat = {sum_wide[SW-1], {(DATA_WIDTH_RES-1){~sum_wide[SW-1]}}};
    else
      sum_sat = sum_wide[DATA_WIDTH_RES-1:0];
  end

  always_comb begin
    v_d   = v_q;
    tag_d = tag_q;
    sum_d = sum_q;
    ptr_d = ptr_q;
    if (fire) begin
      v_d   = 1'b1;
      tag_d = sel;
      sum_d = sum_sat;
    end else if (write) begin
      v_d = 1'b0;
    end
`ifdef ADD_PRED_RES_RR_ARB_EN
    if (fire) ptr_d = TW'((int'(sel) + 1) % FLUX);
`else
    ptr_d = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= 1'b0;
      tag_q <= '0;
      sum_q <= '0;
      ptr_q <= '0;
    end else begin
      v_q   <= v_d;
      tag_q <= tag_d;
      sum_q <= sum_d;
      ptr_q <= ptr_d;
    end
  end

  // Reads are gated by rst so an asserted reset kills pops immediately.
  always_comb begin
    read_port_in_pred_read = '0;
    read_port_in_res_read  = '0;
    if (fire && !rst) begin
      read_port_in_pred_read = FLUX'(1) << sel;
      read_port_in_res_read  = FLUX'(1) << sel;
    end
  end

  assign write_port_out_pel_write = write;

  generate
    if (TAG_WIDTH > 0) begin : g_tagged
      assign write_port_out_pel_din = {tag_q[TAG_WIDTH-1:0], sum_q};
    end else begin : g_untagged
      assign write_port_out_pel_din = sum_q;
    end
  endgenerate
endmodule
